// File: rtl/adc_responder.sv
// adc_responder
//   Stand-in for the dual-output serial ADC on the far side of the pong ADC
//   pins. It follows the controller's ADC_CS_N / ADC_SCLK framing and shifts
//   two DATA_W-bit samples out on ADC_DOUT, changing on SCLK falling edges so
//   the controller can sample on the rising edges. Samples are taken from
//   parallel inputs, for example paddle position counters.
//
//   Ports
//     clock_50MHz            system clock, rising edge
//     RESET_n                asynchronous active-low reset
//     ADC_CS_N, ADC_SCLK     frame select / serial clock from the controller
//     ADC_SEL                0: vin1 pair, 1: vin2 pair
//     ADC_UB                 1: two's complement output (sample MSB inverted)
//     ADC_SD, ADC_REFSEL,
//     ADC_CNVST              reserved, ignored
//     vin1_a/b, vin2_a/b     parallel samples
//     ADC_DOUT               serial data, bit0 = channel A, bit1 = channel B
//     busy                   frame in progress
//     frame_done             one-cycle pulse when a frame completes
//     aborted                one-cycle pulse when CS_N rises mid-frame
//     frame_count            completed frames, wraps at 256
//
//   Build option
//     ADC_RESPONDER_NOISE_EN adds a +1/0/0/-1 LSB dither, driven by a 16-bit
//                            LFSR stepped at every frame start, to each
//                            latched sample (saturating at 0 and full scale).

module adc_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned LEAD_ZEROS  = 2,
  parameter int unsigned SYNC_STAGES = 2   // must be at least 2
) (
  input  logic              clock_50MHz,
  input  logic              RESET_n,
  input  logic              ADC_CS_N,
  input  logic              ADC_SCLK,
  input  logic              ADC_SEL,
  input  logic              ADC_UB,
  input  logic              ADC_SD,
  input  logic              ADC_REFSEL,
  input  logic              ADC_CNVST,
  input  logic [DATA_W-1:0] vin1_a,
  input  logic [DATA_W-1:0] vin1_b,
  input  logic [DATA_W-1:0] vin2_a,
  input  logic [DATA_W-1:0] vin2_b,
  output logic [1:0]        ADC_DOUT,
  output logic              busy,
  output logic              frame_done,
  output logic              aborted,
  output logic [7:0]        frame_count
);

  localparam int unsigned FRAME_BITS = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

  logic unused_pins;
  assign unused_pins = ^{ADC_SD, ADC_REFSEL, ADC_CNVST};

  // ---------------------------------------------------------------------
  // Pin synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, fill_q;
  logic                   cs_prev_q, sclk_prev_q, armed_q;
  logic                   cs_s, sclk_s, cs_fall, cs_rise, sclk_fall;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      // The synchronizers reset to 1, so a CS_N held low through reset would
      // look like a falling edge. Only arm once the flushed chain shows a
      // genuine high on CS_N.
      if (fill_q[SYNC_STAGES-1] && cs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // ---------------------------------------------------------------------
  // Sample selection for the next frame
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] pick_a, pick_b, adj_a, adj_b, ub_mask;
  logic [DATA_W-1:0] shadow_a_d, shadow_b_d;

`ifdef ADC_RESPONDER_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // x^16 + x^14 + x^13 + x^11 + 1
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  function automatic logic [DATA_W-1:0] dither(input logic [DATA_W-1:0] v,
                                               input logic [1:0]        sel);
    logic [DATA_W-1:0] r;
    r = v;
    if (sel == 2'b00 && v != '1) r = v + DATA_W'(1);
    if (sel == 2'b11 && v != '0) r = v - DATA_W'(1);
    return r;
  endfunction
`endif

  always_comb begin
    pick_a  = ADC_SEL ? vin2_a : vin1_a;
    pick_b  = ADC_SEL ? vin2_b : vin1_b;
`ifdef ADC_RESPONDER_NOISE_EN
    adj_a   = dither(pick_a, lfsr_q[1:0]);
    adj_b   = dither(pick_b, lfsr_q[1:0]);
`else
    adj_a   = pick_a;
    adj_b   = pick_b;
`endif
    ub_mask    = {ADC_UB, {(DATA_W-1){1'b0}}};
    shadow_a_d = adj_a ^ ub_mask;
    shadow_b_d = adj_b ^ ub_mask;
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t            state_q;
  logic [CNT_W-1:0]  bit_cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_a_q, shift_b_q;
  logic              in_data;

  assign cnt_d   = bit_cnt_q + CNT_W'(1);
  assign in_data = (cnt_d >= CNT_W'(LEAD_ZEROS)) && (cnt_d < CNT_W'(FRAME_BITS));

  always_ff @(posedge clock_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      ADC_DOUT    <= 2'b00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      aborted     <= 1'b0;
      frame_count <= '0;
      bit_cnt_q   <= '0;
      shift_a_q   <= '0;
      shift_b_q   <= '0;
`ifdef ADC_RESPONDER_NOISE_EN
      lfsr_q      <= 16'hACE1;
`endif
    end else begin
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      case (state_q)
        IDLE: begin
          ADC_DOUT <= 2'b00;
          busy     <= 1'b0;
          if (cs_fall) begin
            // Working copies of the samples; they shift left so the current
            // data bit is always at the MSB. Pin changes after this point
            // cannot reach the frame.
            shift_a_q <= shadow_a_d;
            shift_b_q <= shadow_b_d;
            bit_cnt_q <= '0;
            busy      <= 1'b1;
            state_q   <= SHIFT;
`ifdef ADC_RESPONDER_NOISE_EN
            lfsr_q    <= lfsr_d;
`endif
          end
        end
        SHIFT: begin
          // CS_N rising takes priority over a coincident SCLK fall.
          if (cs_rise) begin
            ADC_DOUT <= 2'b00;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            state_q  <= IDLE;
          end else if (sclk_fall) begin
            bit_cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(FRAME_BITS)) begin
              ADC_DOUT    <= 2'b00;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              state_q     <= TAIL;
            end else if (in_data) begin
              ADC_DOUT  <= {shift_b_q[DATA_W-1], shift_a_q[DATA_W-1]};
              shift_a_q <= shift_a_q << 1;
              shift_b_q <= shift_b_q << 1;
            end else begin
              ADC_DOUT <= 2'b00;
            end
          end
        end
        TAIL: begin
          ADC_DOUT <= 2'b00;
          if (cs_rise) begin
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ADC_DOUT <= 2'b00;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- Synthesizable model of the dual-output serial ADC that sits on the far side of the pong ADC pins.
- Responds to the ADC controller's CS_N/SCLK framing by shifting two 12-bit samples out on ADC_DOUT[1:0].
- Samples come from parallel inputs, such as paddle position counters driven by push buttons.
- Used for board-less play and as the bench responder for the ADC controller.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 2, zero bits preceding the sample MSB in each frame.
- SYNC_STAGES, 2, synchronizer depth on ADC_SCLK and ADC_CS_N (minimum 2).

Ports:
- clock_50MHz  input  1  system clock; all logic on its rising edge.
- RESET_n  input  1  asynchronous active-low reset.
- ADC_CS_N  input  1  frame select from the controller, active low.
- ADC_SCLK  input  1  serial clock from the controller; at most clock_50MHz/8.
- ADC_SEL  input  1  0 selects the vin1 pair, 1 selects the vin2 pair.
- ADC_UB  input  1  0 = straight binary output, 1 = two's complement output (MSB inverted).
- ADC_SD  input  1  reserved; ignored.
- ADC_REFSEL  input  1  reserved; ignored.
- ADC_CNVST  input  1  reserved; ignored.
- vin1_a, vin1_b  input  DATA_W each  channel A/B samples for pair 1.
- vin2_a, vin2_b  input  DATA_W each  channel A/B samples for pair 2.
- ADC_DOUT  output  2  serial data; bit0 = channel A, bit1 = channel B.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse on frame completion.
- aborted  output  1  one-cycle pulse when CS_N rises mid-frame.
- frame_count  output  8  count of completed frames; wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, RESET_n=0):
  - ADC_DOUT=2'b00, busy=0, frame_done=0, aborted=0, frame_count=0.
  - State IDLE; synchronizers load 1 (CS_N idle high, SCLK idle high).
- Inputs: ADC_CS_N and ADC_SCLK pass through SYNC_STAGES flops. Edge detection compares the last two synchronized values.
- Latency: a pin edge produces a DOUT/state change SYNC_STAGES+1 clocks later (3 with defaults).
- States: IDLE, SHIFT, TAIL.
- IDLE:
  - ADC_DOUT=00, busy=0.
  - On CS_N falling:
    - Latch shadow_a/shadow_b from the pair chosen by ADC_SEL, MSB-inverted if ADC_UB=1.
    - bit_cnt=0, DOUT=00 (first leading zero), busy=1, go to SHIFT.
- SHIFT, on each synced SCLK falling edge:
  - bit_cnt increments, then DOUT shows the bit at position bit_cnt.
  - Positions 0..LEAD_ZEROS-1 are 0; positions LEAD_ZEROS..LEAD_ZEROS+DATA_W-1 are MSB..LSB; later positions are 0.
  - At the falling edge where bit_cnt reaches LEAD_ZEROS+DATA_W (14 by default): DOUT=00, frame_done=1 for one clock, frame_count+1, go to TAIL.
  - busy stays 1 in TAIL.
- TAIL: DOUT held at 00; extra SCLK edges are ignored.
- CS_N rising:
  - In TAIL: go to IDLE, busy=0.
  - In SHIFT: go to IDLE, DOUT=00, busy=0, aborted=1 for one clock; frame_count unchanged and no frame_done.
- Simultaneous events:
  - CS_N falling and SCLK falling in the same synced cycle: CS edge wins, that SCLK edge is ignored.
  - CS_N rising and SCLK falling in the same cycle: CS edge wins.
- vin*/ADC_SEL/ADC_UB changes during a frame do not affect the frame; the shadow registers hold. New values are used on the next CS_N fall.
- CS_N falling while in TAIL cannot occur, since CS_N must rise first. If CS_N is low out of reset, no frame starts until a genuine falling edge.
- Reset asserted mid-frame: immediate return to reset values, no frame_done and no aborted pulse.
- SCLK rising edges are never used; the controller samples DOUT on them.

Optional Feature:
- Macro: ADC_RESPONDER_NOISE_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) steps once per frame start.
  - LFSR bits [1:0] select +1, 0, 0, -1 LSB, added to each shadow sample before the UB transform.
  - The result saturates at 0 and 2^DATA_W-1.
- Undefined: shadow samples are exact copies; no LFSR is present.

Test Plan:
- Reset, then one frame with vin1_a=12'hABC, vin1_b=12'h123, SEL=0, UB=0, 16 SCLK periods -> DOUT[0] bits 00101010111100, DOUT[1] bits 00000100100011, then 00; frame_done pulse, frame_count=1.
- Same frame with SEL=1, vin2_a=12'h800, UB=1 -> channel A bits 00 followed by 12'h000; busy high from CS fall+3 clocks until CS rise+3 clocks.
- CS_N rises after 6 SCLK falls -> aborted=1 for one clock, frame_count unchanged, DOUT=00, state IDLE; the next full frame completes normally.
- Change vin1_a from 12'h0F0 to 12'hFFF mid-frame -> the frame still shifts 12'h0F0; the next frame shifts 12'hFFF.
- Run 256 frames -> frame_count wraps to 0 with exactly 256 frame_done pulses.
- With ADC_RESPONDER_NOISE_EN and vin1_a=12'hFFF or 12'h000 -> output never exceeds FFF or drops below 000; with 12'h400 the output stays within 3FF..401.
